// File: rtl/lifo_param.sv
// lifo_param -- parameterised stack (LIFO) with registered pop data,
// occupancy count, threshold flags and overflow/underflow reporting.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   wr / rd       push / pop requests (both together = replace top)
//   clr_err       clears sticky error flags (sticky build only)
//   data_in       push data
//   data_out      registered popped word
//   rd_valid      one-cycle pulse: data_out was updated by a pop
//   count         current occupancy
//   empty, full   count==0, count==DEPTH
//   lifo_low_th   count<=LOW_TH
//   lifo_high_th  count>=HIGH_TH
//   lifo_ov       push while full (and no pop)
//   lifo_ud       pop while empty (and no push)
//
// Build option: define LIFO_STICKY_ERR_EN to make lifo_ov/lifo_ud sticky
// until clr_err or rst; otherwise they are single-cycle pulses.

module lifo_param #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int LOW_TH  = 2,
    parameter int HIGH_TH = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic                       rd,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       lifo_low_th,
    output logic                       lifo_high_th,
    output logic                       lifo_ov,
    output logic                       lifo_ud
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LOW_C   = CW'(LOW_TH);
    localparam logic [CW-1:0] HIGH_C  = CW'(HIGH_TH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          push_ok, pop_ok, swap, ov_ev, ud_ev;
    logic [AW-1:0] wr_idx, top_idx;

    // Status flags decode straight from the registered count.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign lifo_low_th  = (count <= LOW_C);
    assign lifo_high_th = (count >= HIGH_C);

    assign push_ok = wr && !rd && !full;
    assign pop_ok  = rd && !wr && !empty;
    assign swap    = wr && rd;
    assign ov_ev   = wr && !rd && full;
    assign ud_ev   = rd && !wr && empty;

    // wr_idx is only used when not full, top_idx only when not empty,
    // so truncation to AW bits never loses information where it matters.
    assign wr_idx  = AW'(count);
    assign top_idx = AW'(count - ONE_C);

    // Storage: no reset; stale entries are unreachable above count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push_ok)
                mem[wr_idx] <= data_in;
            else if (swap && !empty)
                mem[top_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (push_ok) begin
                count <= count + ONE_C;
            end else if (pop_ok) begin
                count    <= count - ONE_C;
                data_out <= mem[top_idx];
                rd_valid <= 1'b1;
            end else if (swap) begin
                // Replace top: old top comes out, new word takes its slot.
                // On an empty stack the incoming word passes straight through.
                data_out <= empty ? data_in : mem[top_idx];
                rd_valid <= 1'b1;
            end
        end
    end

`ifdef LIFO_STICKY_ERR_EN
    // A new event in the same cycle as clr_err wins, so nothing is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            lifo_ov <= 1'b0;
            lifo_ud <= 1'b0;
        end else begin
            lifo_ov <= (lifo_ov && !clr_err) || ov_ev;
            lifo_ud <= (lifo_ud && !clr_err) || ud_ev;
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            lifo_ov <= 1'b0;
            lifo_ud <= 1'b0;
        end else begin
            lifo_ov <= ov_ev;
            lifo_ud <= ud_ev;
        end
    end
`endif

endmodule

// File: doc/lifo_param.md
LIFO_PARAM -- requirements
Module: lifo_param

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of stack entries (power of 2, >=2).
REQ-003 Parameter LOW_TH, default 2, low-threshold occupancy (0 <= LOW_TH < DEPTH).
REQ-004 Parameter HIGH_TH, default 14, high-threshold occupancy (LOW_TH < HIGH_TH <= DEPTH).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr  input  1  push request.
REQ-008 rd  input  1  pop request.
REQ-009 clr_err  input  1  clears sticky error flags (LIFO_STICKY_ERR_EN only; ignored otherwise).
REQ-010 data_in  input  WIDTH  push data.
REQ-011 data_out  output  WIDTH  registered popped word.
REQ-012 rd_valid  output  1  one-cycle pulse, data_out updated by a pop this cycle.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-014 empty, full  output  1 each  count==0, count==DEPTH.
REQ-015 lifo_low_th, lifo_high_th  output  1 each  count<=LOW_TH, count>=HIGH_TH.
REQ-016 lifo_ov, lifo_ud  output  1 each  overflow (push while full), underflow (pop while empty).

Function
REQ-017 Push (wr=1, rd=0, !full): mem[count]<=data_in, count+1 next cycle; data_out unchanged.
REQ-018 Pop (rd=1, wr=0, !empty): data_out<=mem[count-1], count-1, rd_valid=1 the following cycle (latency 1).
REQ-019 Push+pop, !empty: data_out<=old top, top overwritten with data_in, count unchanged, rd_valid=1.
REQ-020 Push+pop, empty: data_out<=data_in (bypass), count stays 0, rd_valid=1, no underflow.
REQ-021 Push while full (rd=0): data dropped, memory and count unchanged, lifo_ov asserted next cycle.
REQ-022 Pop while empty (wr=0): data_out holds, rd_valid=0, lifo_ud asserted next cycle.
REQ-023 Push+pop while full: handled per REQ-019; no overflow.
REQ-024 empty, full, lifo_low_th, lifo_high_th decoded combinationally from registered count; valid in same cycle count changes.
REQ-025 count never exceeds DEPTH nor wraps below 0; stack pointer arithmetic saturating by construction.
REQ-026 Idle (wr=0, rd=0): all state held; rd_valid=0.

Reset
REQ-027 rst=1 at rising edge: count=0, data_out=0, rd_valid=0, lifo_ov=0, lifo_ud=0; empty=1, full=0, lifo_low_th=1, lifo_high_th=0.
REQ-028 Memory contents not reset; unreachable until rewritten.
REQ-029 rst dominates wr/rd in same cycle; in-flight operation discarded, no rd_valid pulse.

Configuration
REQ-030 Macro LIFO_STICKY_ERR_EN selects error-flag behaviour.
REQ-031 Defined: lifo_ov/lifo_ud set on event, held until clr_err=1 or rst; clr_err and new event same cycle -> flag stays set.
REQ-032 Undefined: lifo_ov/lifo_ud are single-cycle pulses, one cycle after offending request; clr_err has no effect.

Verification (WIDTH=32, DEPTH=4, LOW_TH=1, HIGH_TH=3)
REQ-033 Reset then push 0x11,0x22,0x33,0x44 -> count 1..4, high_th at count=3, full=1 at 4, low_th=0 from count=2.
REQ-034 From full, pop x4 -> data_out 0x44,0x33,0x22,0x11 each with rd_valid=1 one cycle after rd; empty=1 at end.
REQ-035 Push 0xAA with full -> count stays 4, lifo_ov=1 next cycle (pulse, or held until clr_err with LIFO_STICKY_ERR_EN); later pop returns 0x44.
REQ-036 Pop when empty -> lifo_ud=1 next cycle, rd_valid=0, data_out unchanged, count 0.
REQ-037 count=2 (top 0x22), wr=rd=1 with 0x55 -> data_out=0x22, count=2, next pop returns 0x55; empty with wr=rd=1, 0x77 -> data_out=0x77, count=0.
REQ-038 rst=1 with wr=1 at count=3 -> next cycle count=0, all flags at reset values, rd_valid=0.
